// File: rtl/sha3_hps_sequencer.sv
// rtl/sha3_hps_sequencer.sv - HPS flag handshake sequencer driving a SHA3 hash core
module sha3_hps_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic         clk_clk,
    input  logic         reset_reset,
    input  logic [31:0]  sha_in0,
    input  logic [31:0]  sha_in1,
    input  logic [31:0]  sha_in2,
    input  logic [31:0]  sha_in3,
    input  logic [31:0]  sha_in4,
    input  logic [31:0]  sha_in5,
    input  logic [31:0]  sha_in6,
    input  logic [31:0]  sha_in7,
    input  logic [31:0]  round_const0,
    input  logic [31:0]  round_const1,
    input  logic         flag_out,
    output logic         flag_in,
    output logic [31:0]  sha_out0,
    output logic [31:0]  sha_out1,
    output logic [31:0]  sha_out2,
    output logic [31:0]  sha_out3,
    output logic [31:0]  sha_out4,
    output logic [31:0]  sha_out5,
    output logic [31:0]  sha_out6,
    output logic [31:0]  sha_out7,
    output logic [255:0] core_block,
    output logic [63:0]  core_rc,
    output logic         core_start,
    input  logic         core_done,
    input  logic [255:0] core_digest,
    output logic         err,
    output logic [15:0]  op_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic          flag_q;
    logic          flag_in_q, flag_in_d;
    logic          start_q, start_d;
    logic          err_q, err_d;
    logic [15:0]   op_q, op_d;
    logic [255:0]  dig_q, dig_d;
    logic [255:0]  blk_q, blk_d;
    logic [63:0]   rc_q, rc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req;

    // A request is a rising level on flag_out; flag_q resets high so a level
    // already present at reset release is not mistaken for a new request.
    assign req = flag_out & ~flag_q;

    // Next-state and datapath decisions for the handshake FSM.
    always_comb begin
        state_d   = state_q;
        flag_in_d = flag_in_q;
        start_d   = 1'b0;
        err_d     = err_q;
        op_d      = op_q;
        dig_d     = dig_q;
        blk_d     = blk_q;
        rc_d      = rc_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    blk_d   = {sha_in7, sha_in6, sha_in5, sha_in4,
                               sha_in3, sha_in2, sha_in1, sha_in0};
                    rc_d    = {round_const1, round_const0};
                    state_d = S_START;
                end
            end
            S_START: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // core_done wins over a timeout landing in the same cycle.
                if (core_done) begin
                    dig_d     = core_digest;
                    flag_in_d = 1'b1;
                    op_d      = op_q + 16'd1;
                    state_d   = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    dig_d     = '0;
                    err_d     = 1'b1;
                    flag_in_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (!flag_out) begin
                    flag_in_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q   <= S_IDLE;
            flag_q    <= 1'b1;
            flag_in_q <= 1'b0;
            start_q   <= 1'b0;
            err_q     <= 1'b0;
            op_q      <= '0;
            dig_q     <= '0;
            blk_q     <= '0;
            rc_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            flag_q    <= flag_out;
            flag_in_q <= flag_in_d;
            start_q   <= start_d;
            err_q     <= err_d;
            op_q      <= op_d;
            dig_q     <= dig_d;
            blk_q     <= blk_d;
            rc_q      <= rc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign flag_in    = flag_in_q;
    assign core_start = start_q;
    assign err        = err_q;
    assign op_count   = op_q;
    assign core_block = blk_q;
    assign core_rc    = rc_q;
    assign sha_out0   = dig_q[31:0];
    assign sha_out1   = dig_q[63:32];
    assign sha_out2   = dig_q[95:64];
    assign sha_out3   = dig_q[127:96];
    assign sha_out4   = dig_q[159:128];
    assign sha_out5   = dig_q[191:160];
    assign sha_out6   = dig_q[223:192];
    assign sha_out7   = dig_q[255:224];

endmodule

// File: tb/tb_sha3_hps_sequencer.sv
// tb/tb_sha3_hps_sequencer.sv - self-checking bench for sha3_hps_sequencer
module tb_sha3_hps_sequencer;

    localparam int TO = 16;

    logic         clk_clk = 1'b0;
    logic         reset_reset;
    logic [255:0] in_blk;
    logic [63:0]  in_rc;
    logic         flag_out;
    logic         flag_in;
    logic [31:0]  sha_out0, sha_out1, sha_out2, sha_out3;
    logic [31:0]  sha_out4, sha_out5, sha_out6, sha_out7;
    logic [255:0] core_block;
    logic [63:0]  core_rc;
    logic         core_start;
    logic         core_done;
    logic [255:0] core_digest;
    logic         err;
    logic [15:0]  op_count;
    logic [255:0] out_all;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;

    assign out_all = {sha_out7, sha_out6, sha_out5, sha_out4,
                      sha_out3, sha_out2, sha_out1, sha_out0};

    sha3_hps_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .sha_in0      (in_blk[31:0]),
        .sha_in1      (in_blk[63:32]),
        .sha_in2      (in_blk[95:64]),
        .sha_in3      (in_blk[127:96]),
        .sha_in4      (in_blk[159:128]),
        .sha_in5      (in_blk[191:160]),
        .sha_in6      (in_blk[223:192]),
        .sha_in7      (in_blk[255:224]),
        .round_const0 (in_rc[31:0]),
        .round_const1 (in_rc[63:32]),
        .flag_out     (flag_out),
        .flag_in      (flag_in),
        .sha_out0     (sha_out0),
        .sha_out1     (sha_out1),
        .sha_out2     (sha_out2),
        .sha_out3     (sha_out3),
        .sha_out4     (sha_out4),
        .sha_out5     (sha_out5),
        .sha_out6     (sha_out6),
        .sha_out7     (sha_out7),
        .core_block   (core_block),
        .core_rc      (core_rc),
        .core_start   (core_start),
        .core_done    (core_done),
        .core_digest  (core_digest),
        .err          (err),
        .op_count     (op_count)
    );

    always #5 clk_clk = ~clk_clk;

    always @(negedge clk_clk) begin
        if (core_start) start_cnt <= start_cnt + 1;
    end

    typedef struct {
        logic [255:0] blk;
        logic [63:0]  rc;
        logic [255:0] dig;
        int           delay;
        bit           early;
        logic [255:0] exp_sha;
        bit           exp_err;
        logic [15:0]  exp_op;
    } vec_t;

    typedef struct {
        logic [255:0] sha;
        bit           err;
        logic [15:0]  op;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[6];

    task automatic tick();
        @(negedge clk_clk);
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_sb: got flag_in with empty scoreboard, expected none", tag);
            return;
        end
        e = sbq.pop_front();
        check({tag, "_sha"}, out_all, e.sha);
        check({tag, "_err"}, 256'(err), 256'(e.err));
        check({tag, "_op"}, 256'(op_count), 256'(e.op));
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int   n;
        int   s0;
        exp_t e;
        in_blk   = v.blk;
        in_rc    = v.rc;
        flag_out = 1'b1;
        e.sha = v.exp_sha;
        e.err = v.exp_err;
        e.op  = v.exp_op;
        sbq.push_back(e);
        s0 = start_cnt;
        tick();
        check({tag, "_start_t1"}, 256'(core_start), 256'(0));
        if (v.early) flag_out = 1'b0;
        tick();
        check({tag, "_start_t2"}, 256'(core_start), 256'(1));
        check({tag, "_blk"}, core_block, v.blk);
        check({tag, "_rc"}, 256'(core_rc), 256'(v.rc));
        if (v.delay >= 0) begin
            repeat (v.delay) tick();
            check({tag, "_pre_done"}, 256'(flag_in), 256'(0));
            core_digest = v.dig;
            core_done   = 1'b1;
            tick();
            core_done   = 1'b0;
            core_digest = '0;
            check({tag, "_done_lat"}, 256'(flag_in), 256'(1));
        end else begin
            n = 0;
            while (!flag_in && n < 100) begin
                tick();
                n++;
            end
            check({tag, "_to_lat"}, 256'(n), 256'(TO));
        end
        sb_pop(tag);
        check({tag, "_starts"}, 256'(start_cnt - s0), 256'(1));
        if (!v.early) begin
            tick();
            check({tag, "_hold"}, 256'(flag_in), 256'(1));
            flag_out = 1'b0;
        end
        tick();
        check({tag, "_release"}, 256'(flag_in), 256'(0));
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   s0;
        exp_t e;
        vec_t w;

        vecs[0] = '{{32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1},
                    64'h80000000_00000001, {32{8'hA5}}, 10, 1'b0,
                    {32{8'hA5}}, 1'b0, 16'd1};
        vecs[1] = '{{8{32'h0123_4567}}, 64'hDEADBEEF_CAFEF00D,
                    {4{64'hFEDC_BA98_7654_3210}}, 0, 1'b0,
                    {4{64'hFEDC_BA98_7654_3210}}, 1'b0, 16'd2};
        vecs[2] = '{{16{16'h5A3C}}, 64'h1111_2222_3333_4444,
                    {8{32'h1357_9BDF}}, 3, 1'b1,
                    {8{32'h1357_9BDF}}, 1'b0, 16'd3};
        vecs[3] = '{{8{32'hFFFF_0000}}, 64'hFFFF_FFFF_FFFF_FFFF,
                    {8{32'h0F0F_0F0F}}, TO - 1, 1'b0,
                    {8{32'h0F0F_0F0F}}, 1'b0, 16'd4};
        vecs[4] = '{{8{32'hAAAA_5555}}, 64'h0, {8{32'h7777_7777}}, -1, 1'b0,
                    256'h0, 1'b1, 16'd4};
        vecs[5] = '{{8{32'h2468_ACE0}}, 64'h0BAD_F00D_0000_0001,
                    {8{32'hC001_D00D}}, 2, 1'b0,
                    {8{32'hC001_D00D}}, 1'b1, 16'd5};

        reset_reset = 1'b1;
        flag_out    = 1'b1;
        core_done   = 1'b0;
        core_digest = '0;
        in_blk      = {8{32'hDEAD_BEEF}};
        in_rc       = 64'h1234_5678_9ABC_DEF0;
        repeat (3) tick();
        reset_reset = 1'b0;
        check("rst_flag_in", 256'(flag_in), 256'(0));
        check("rst_start", 256'(core_start), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        check("rst_op", 256'(op_count), 256'(0));
        check("rst_sha", out_all, 256'h0);
        check("rst_blk", core_block, 256'h0);
        check("rst_rc", 256'(core_rc), 256'h0);
        repeat (4) tick();
        check("rst_high_no_req", 256'(start_cnt), 256'(0));
        flag_out = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Spurious core_done in IDLE, second flag_out edge in RUN, core_done in DONE.
        s0 = start_cnt;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        check("ign_idle_flag", 256'(flag_in), 256'(0));
        check("ign_idle_op", 256'(op_count), 256'(5));
        in_blk   = {8{32'h3141_5926}};
        flag_out = 1'b1;
        e.sha = {8{32'h2718_2818}};
        e.err = 1'b1;
        e.op  = 16'd6;
        sbq.push_back(e);
        tick();
        tick();
        flag_out = 1'b0;
        tick();
        flag_out = 1'b1;
        tick();
        core_digest = {8{32'h2718_2818}};
        core_done   = 1'b1;
        tick();
        core_done   = 1'b0;
        check("ign_flag_in", 256'(flag_in), 256'(1));
        sb_pop("ign");
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        check("ign_done_op", 256'(op_count), 256'(6));
        flag_out = 1'b0;
        tick();
        check("ign_release", 256'(flag_in), 256'(0));
        repeat (4) tick();
        check("ign_starts", 256'(start_cnt - s0), 256'(1));

        // Reset in RUN with flag_out held high, followed by a stale core_done.
        in_blk   = {8{32'h0BAD_CAFE}};
        flag_out = 1'b1;
        tick();
        tick();
        tick();
        reset_reset = 1'b1;
        tick();
        reset_reset = 1'b0;
        sbq.delete();
        s0 = start_cnt;
        check("mid_rst_err", 256'(err), 256'(0));
        check("mid_rst_op", 256'(op_count), 256'(0));
        check("mid_rst_blk", core_block, 256'h0);
        core_digest = {8{32'h9999_9999}};
        core_done   = 1'b1;
        tick();
        core_done   = 1'b0;
        core_digest = '0;
        repeat (4) tick();
        check("mid_rst_flag_in", 256'(flag_in), 256'(0));
        check("mid_rst_sha", out_all, 256'h0);
        check("mid_rst_starts", 256'(start_cnt - s0), 256'(0));
        flag_out = 1'b0;
        tick();
        w = vecs[1];
        w.exp_op = 16'd1;
        run_txn(w, "post_rst");

        // Counter wrap combined with core_done landing in the timeout cycle.
        force dut.op_q = 16'hFFFF;
        tick();
        release dut.op_q;
        tick();
        check("wrap_preload", 256'(op_count), 256'(16'hFFFF));
        w = vecs[3];
        w.exp_op = 16'h0000;
        run_txn(w, "wrap");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
